// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: handshaked data-memory access with stall/timeout,
// redirect resolution and the MEM/WB pipeline register.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RegWriteIn,
  input  logic        MemWriteIn,
  input  logic        MemReadIn,
  input  logic        BranchIn,
  input  logic        MemToRegIn,
  input  logic        JumpIn,
  input  logic        JrIn,
  input  logic        JalIn,
  input  logic        ZeroIn,
  input  logic [31:0] RData2In,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] PCAddResultIn,
  input  logic [31:0] BranchPCIn,
  input  logic [4:0]  RdRegIn,
  output logic        DmReq,
  output logic        DmWe,
  output logic [31:0] DmAddr,
  output logic [31:0] DmWData,
  input  logic        DmReady,
  input  logic        DmRValid,
  input  logic [31:0] DmRData,
  output logic        Stall,
  output logic        PCSrc,
  output logic [31:0] PCTarget,
  output logic        Flush,
  output logic        MemErr,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic        JalOut,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] PCAddResultOut,
  output logic [4:0]  RdRegOut
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_RD = 2'd2} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_r, state_nxt_s;
  logic [7:0]  to_cnt_r, to_cnt_nxt_s;
  logic        mem_op_s, is_read_s, is_write_s, misalign_s, timeout_s;
  logic        req_s, done_s, bubble_s, err_s;
  logic        redir_s;
  logic [31:0] tgt_s;

  // Read wins when both read and write are requested.
  assign mem_op_s   = MemReadIn | MemWriteIn;
  assign is_read_s  = MemReadIn;
  assign is_write_s = MemWriteIn & ~MemReadIn;
  assign misalign_s = mem_op_s & (ALUResultIn[1:0] != 2'b00);
  assign timeout_s  = (state_r != IDLE) && (to_cnt_r == TO_LAST);

  // Next-state, request and completion decode.
  always_comb begin
    state_nxt_s = state_r;
    req_s       = 1'b0;
    done_s      = 1'b0;
    bubble_s    = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!mem_op_s) begin
          done_s = 1'b1;
        end else if (misalign_s) begin
          done_s   = 1'b1;
          bubble_s = 1'b1;
          err_s    = 1'b1;
        end else begin
          req_s = 1'b1;
          if (DmReady && is_write_s) begin
            done_s = 1'b1;
          end else if (DmReady) begin
            state_nxt_s = WAIT_RD;
          end else begin
            state_nxt_s = REQ;
          end
        end
      end
      REQ: begin
        // Abort drops the request so a late DmReady cannot be taken as acceptance.
        if (timeout_s) begin
          done_s      = 1'b1;
          bubble_s    = 1'b1;
          err_s       = 1'b1;
          state_nxt_s = IDLE;
        end else if (DmReady && is_write_s) begin
          req_s       = 1'b1;
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (DmReady) begin
          req_s       = 1'b1;
          state_nxt_s = WAIT_RD;
        end else begin
          req_s = 1'b1;
        end
      end
      WAIT_RD: begin
        if (timeout_s) begin
          done_s      = 1'b1;
          bubble_s    = 1'b1;
          err_s       = 1'b1;
          state_nxt_s = IDLE;
        end else if (DmRValid) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_RD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Redirect target selection, Jr highest priority.
  always_comb begin
    redir_s = 1'b0;
    tgt_s   = BranchPCIn;
    if (JrIn) begin
      redir_s = 1'b1;
      tgt_s   = ALUResultIn;
    end else if (JumpIn || JalIn || (BranchIn && ZeroIn)) begin
      redir_s = 1'b1;
    end else begin
      redir_s = 1'b0;
    end
  end

  assign to_cnt_nxt_s = ((state_r == IDLE) || (state_nxt_s == IDLE)) ? 8'd0 : (to_cnt_r + 8'd1);

  assign DmReq   = req_s & Reset;
  assign DmWe    = req_s & Reset & is_write_s;
  assign DmAddr  = ALUResultIn;
  assign DmWData = RData2In;
  assign Stall   = Reset & mem_op_s & ~done_s;

  // State, timeout counter, sticky error and MEM/WB register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r        <= IDLE;
      to_cnt_r       <= 8'd0;
      MemErr         <= 1'b0;
      PCSrc          <= 1'b0;
      Flush          <= 1'b0;
      PCTarget       <= 32'd0;
      RegWriteOut    <= 1'b0;
      MemToRegOut    <= 1'b0;
      JalOut         <= 1'b0;
      ReadDataOut    <= 32'd0;
      ALUResultOut   <= 32'd0;
      PCAddResultOut <= 32'd0;
      RdRegOut       <= 5'd0;
    end else begin
      state_r  <= state_nxt_s;
      to_cnt_r <= to_cnt_nxt_s;
      if (err_s) begin
        MemErr <= 1'b1;
      end
      if (done_s && !bubble_s) begin
        RegWriteOut    <= RegWriteIn | JalIn;
        MemToRegOut    <= MemToRegIn;
        JalOut         <= JalIn;
        ReadDataOut    <= is_read_s ? DmRData : 32'd0;
        ALUResultOut   <= ALUResultIn;
        PCAddResultOut <= PCAddResultIn;
        RdRegOut       <= JalIn ? 5'd31 : RdRegIn;
        PCSrc          <= redir_s;
        Flush          <= redir_s;
        if (redir_s) begin
          PCTarget <= tgt_s;
        end
      end else begin
        RegWriteOut <= 1'b0;
        MemToRegOut <= 1'b0;
        JalOut      <= 1'b0;
        PCSrc       <= 1'b0;
        Flush       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl; a transaction-level model predicts
// per-cycle Stall/DmReq and the MEM/WB register after each edge.
module tb_mem_stage_ctrl;

  localparam int T = 16;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        RegWriteIn, MemWriteIn, MemReadIn, BranchIn, MemToRegIn;
  logic        JumpIn, JrIn, JalIn, ZeroIn;
  logic [31:0] RData2In, ALUResultIn, PCAddResultIn, BranchPCIn;
  logic [4:0]  RdRegIn;
  logic        DmReq, DmWe, DmReady, DmRValid;
  logic [31:0] DmAddr, DmWData, DmRData;
  logic        Stall, PCSrc, Flush, MemErr;
  logic [31:0] PCTarget;
  logic        RegWriteOut, MemToRegOut, JalOut;
  logic [31:0] ReadDataOut, ALUResultOut, PCAddResultOut;
  logic [4:0]  RdRegOut;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk), .Reset(Reset),
    .RegWriteIn(RegWriteIn), .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn),
    .BranchIn(BranchIn), .MemToRegIn(MemToRegIn), .JumpIn(JumpIn), .JrIn(JrIn),
    .JalIn(JalIn), .ZeroIn(ZeroIn), .RData2In(RData2In), .ALUResultIn(ALUResultIn),
    .PCAddResultIn(PCAddResultIn), .BranchPCIn(BranchPCIn), .RdRegIn(RdRegIn),
    .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmWData(DmWData),
    .DmReady(DmReady), .DmRValid(DmRValid), .DmRData(DmRData),
    .Stall(Stall), .PCSrc(PCSrc), .PCTarget(PCTarget), .Flush(Flush), .MemErr(MemErr),
    .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut), .JalOut(JalOut),
    .ReadDataOut(ReadDataOut), .ALUResultOut(ALUResultOut),
    .PCAddResultOut(PCAddResultOut), .RdRegOut(RdRegOut)
  );

  typedef struct {
    logic        rw, mw, mr, br, mtr, j, jr, jal, zero;
    logic [31:0] wdata, alu, pca, bpc;
    logic [4:0]  rd;
    int          d_rdy;
    int          d_rv;
  } op_t;

  int total = 0;
  int bad   = 0;

  logic        m_rw, m_mtr, m_jal, m_pcsrc, m_flush, m_err;
  logic [31:0] m_rdata, m_alu, m_pca, m_tgt;
  logic [4:0]  m_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rw = 1'b0; m_mtr = 1'b0; m_jal = 1'b0; m_pcsrc = 1'b0; m_flush = 1'b0; m_err = 1'b0;
    m_rdata = 32'd0; m_alu = 32'd0; m_pca = 32'd0; m_tgt = 32'd0; m_rd = 5'd0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "/rw"},    32'(RegWriteOut),   32'(m_rw));
    chk({tag, "/mtr"},   32'(MemToRegOut),   32'(m_mtr));
    chk({tag, "/jal"},   32'(JalOut),        32'(m_jal));
    chk({tag, "/pcsrc"}, 32'(PCSrc),         32'(m_pcsrc));
    chk({tag, "/flush"}, 32'(Flush),         32'(m_flush));
    chk({tag, "/tgt"},   PCTarget,           m_tgt);
    chk({tag, "/err"},   32'(MemErr),        32'(m_err));
    chk({tag, "/rdata"}, ReadDataOut,        m_rdata);
    chk({tag, "/alu"},   ALUResultOut,       m_alu);
    chk({tag, "/pca"},   PCAddResultOut,     m_pca);
    chk({tag, "/rd"},    32'(RdRegOut),      32'(m_rd));
  endtask

  task automatic clr_op(output op_t op);
    op.rw = 1'b0; op.mw = 1'b0; op.mr = 1'b0; op.br = 1'b0; op.mtr = 1'b0;
    op.j = 1'b0; op.jr = 1'b0; op.jal = 1'b0; op.zero = 1'b0;
    op.wdata = 32'd0; op.alu = 32'd0; op.pca = 32'd0; op.bpc = 32'd0; op.rd = 5'd0;
    op.d_rdy = 0; op.d_rv = 1;
  endtask

  task automatic apply(input op_t op);
    RegWriteIn = op.rw; MemWriteIn = op.mw; MemReadIn = op.mr; BranchIn = op.br;
    MemToRegIn = op.mtr; JumpIn = op.j; JrIn = op.jr; JalIn = op.jal; ZeroIn = op.zero;
    RData2In = op.wdata; ALUResultIn = op.alu; PCAddResultIn = op.pca;
    BranchPCIn = op.bpc; RdRegIn = op.rd;
  endtask

  // Drives one EX/MEM instruction to completion with a scripted memory response.
  task automatic run_op(input string tag, input op_t op);
    logic        memop, rd_op, wr_op, mis, abort;
    int          c, last;
    logic [31:0] rdat;
    memop = op.mr | op.mw;
    rd_op = op.mr;
    wr_op = op.mw & ~op.mr;
    mis   = memop && (op.alu[1:0] != 2'b00);
    abort = 1'b0;
    last  = 0;
    rdat  = 32'd0;
    if (memop && !mis) begin
      c     = wr_op ? op.d_rdy : op.d_rdy + op.d_rv;
      abort = (c >= T);
      last  = abort ? T : c;
    end
    for (int k = 0; k <= last; k++) begin
      @(negedge Clk);
      if (k == 0) apply(op);
      if (!memop || mis) begin
        DmReady  = 1'($urandom_range(0, 1));
        DmRValid = 1'($urandom_range(0, 1));
      end else if (abort && k == T) begin
        DmReady  = 1'b1;
        DmRValid = 1'b1;
      end else begin
        DmReady  = (k == op.d_rdy) || (k > op.d_rdy && $urandom_range(0, 1) == 1);
        DmRValid = (rd_op && k == op.d_rdy + op.d_rv) ||
                   (k <= op.d_rdy && $urandom_range(0, 1) == 1);
      end
      DmRData = $urandom;
      if (k == last) rdat = DmRData;
      #1;
      chk({tag, "/stall"}, 32'(Stall), 32'(memop && !mis && k < last));
      if (!memop || mis) begin
        chk({tag, "/dmreq"}, 32'(DmReq), 32'd0);
      end else if (!(abort && k == last)) begin
        chk({tag, "/dmreq"}, 32'(DmReq), 32'(k <= op.d_rdy));
        if (k <= op.d_rdy) begin
          chk({tag, "/dmwe"},   32'(DmWe), 32'(wr_op));
          chk({tag, "/dmaddr"}, DmAddr,    op.alu);
          chk({tag, "/dmwd"},   DmWData,   op.wdata);
        end
      end
      @(posedge Clk);
      #1;
      if (k < last || mis || abort) begin
        m_rw = 1'b0; m_mtr = 1'b0; m_jal = 1'b0; m_pcsrc = 1'b0; m_flush = 1'b0;
        if (k == last) m_err = 1'b1;
      end else begin
        m_rw    = op.rw | op.jal;
        m_mtr   = op.mtr;
        m_jal   = op.jal;
        m_alu   = op.alu;
        m_pca   = op.pca;
        m_rd    = op.jal ? 5'd31 : op.rd;
        m_rdata = rd_op ? rdat : 32'd0;
        m_pcsrc = 1'b1;
        if (op.jr) m_tgt = op.alu;
        else if (op.j || op.jal || (op.br && op.zero)) m_tgt = op.bpc;
        else m_pcsrc = 1'b0;
        m_flush = m_pcsrc;
      end
      check_regs(tag);
    end
  endtask

  task automatic gen_op(output op_t op);
    int cls;
    clr_op(op);
    op.alu   = $urandom & 32'hFFFF_FFFC;
    op.wdata = $urandom;
    op.pca   = $urandom;
    op.bpc   = $urandom;
    op.rd    = 5'($urandom_range(0, 31));
    op.d_rdy = $urandom_range(0, 4);
    op.d_rv  = $urandom_range(1, 5);
    if ($urandom_range(0, 7) == 0) begin
      op.d_rdy = $urandom_range(0, 20);
      op.d_rv  = $urandom_range(1, 20);
    end
    cls = $urandom_range(0, 7);
    case (cls)
      0: op.rw = 1'b1;
      1: begin op.mr = 1'b1; op.rw = 1'b1; op.mtr = 1'b1; end
      2: op.mw = 1'b1;
      3: begin
        op.rw = 1'($urandom_range(0, 1)); op.br = 1'($urandom_range(0, 1));
        op.j = 1'($urandom_range(0, 1));  op.jr = 1'($urandom_range(0, 1));
        op.jal = 1'($urandom_range(0, 1)); op.zero = 1'($urandom_range(0, 1));
        op.mtr = 1'($urandom_range(0, 1));
      end
      4: begin
        op.mr  = 1'($urandom_range(0, 1));
        op.mw  = ~op.mr;
        op.alu = op.alu | 32'($urandom_range(1, 3));
      end
      5: begin op.mr = 1'b1; op.mw = 1'b1; op.rw = 1'b1; op.mtr = 1'b1; end
      6: begin op.br = 1'b1; op.zero = 1'($urandom_range(0, 1)); end
      default: begin op.jal = 1'b1; op.rw = 1'($urandom_range(0, 1)); end
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t op;
    model_reset();
    clr_op(op);
    apply(op);
    Reset = 1'b0;
    MemReadIn = 1'b1;
    ALUResultIn = 32'h100;
    DmReady = 1'b1;
    DmRValid = 1'b0;
    DmRData = 32'd0;
    #3;
    chk("rst/dmreq", 32'(DmReq), 32'd0);
    chk("rst/stall", 32'(Stall), 32'd0);
    check_regs("rst");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("rel/dmreq", 32'(DmReq), 32'd1);
    chk("rel/stall", 32'(Stall), 32'd1);
    #1;
    clr_op(op);
    apply(op);
    DmReady = 1'b0;

    clr_op(op); op.mr = 1'b1; op.rw = 1'b1; op.mtr = 1'b1; op.alu = 32'h100; op.rd = 5'd8;
    op.d_rdy = 0; op.d_rv = 3;
    run_op("lw", op);
    chk("lw/rdata", ReadDataOut, m_rdata);

    clr_op(op); op.mw = 1'b1; op.alu = 32'h204; op.wdata = 32'h1234; op.d_rdy = 2;
    run_op("sw", op);

    clr_op(op); op.br = 1'b1; op.zero = 1'b1; op.bpc = 32'h40;
    run_op("beq_t", op);
    clr_op(op); op.br = 1'b1; op.zero = 1'b0; op.bpc = 32'h80;
    run_op("beq_nt", op);

    clr_op(op); op.jal = 1'b1; op.bpc = 32'h400; op.pca = 32'h1C; op.rd = 5'd3;
    run_op("jal", op);
    clr_op(op); op.jr = 1'b1; op.j = 1'b1; op.alu = 32'h80; op.bpc = 32'h999C;
    run_op("jr_j", op);

    clr_op(op); op.mr = 1'b1; op.rw = 1'b1; op.alu = 32'h102;
    run_op("mis", op);
    clr_op(op); op.mr = 1'b1; op.rw = 1'b1; op.mtr = 1'b1; op.alu = 32'h108; op.d_rdy = 0; op.d_rv = 100;
    run_op("tmo_rd", op);
    clr_op(op); op.mw = 1'b1; op.alu = 32'h10C; op.d_rdy = T;
    run_op("tmo_wr", op);
    clr_op(op); op.mr = 1'b1; op.rw = 1'b1; op.alu = 32'h110; op.d_rdy = 3; op.d_rv = T - 4;
    run_op("edge_ok", op);

    for (int i = 0; i < 250; i++) begin
      gen_op(op);
      run_op("rnd", op);
    end

    // Reset in the middle of a read: request must vanish and error must clear.
    clr_op(op); op.mr = 1'b1; op.rw = 1'b1; op.alu = 32'h200;
    @(negedge Clk);
    apply(op);
    DmReady = 1'b1;
    DmRValid = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    DmReady = 1'b0;
    Reset = 1'b0;
    #1;
    model_reset();
    chk("midrst/dmreq", 32'(DmReq), 32'd0);
    chk("midrst/stall", 32'(Stall), 32'd0);
    check_regs("midrst");
    clr_op(op);
    apply(op);
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 40; i++) begin
      gen_op(op);
      run_op("rnd2", op);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage controller that consumes the EX/MEM pipeline register outputs of the pipelined MIPS core. It drives a handshaked, possibly multi-cycle data memory and stalls upstream stages while an access is pending. It resolves branch, jump, jr and jal redirects and flushes. It registers the MEM/WB outputs for the write-back stage.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a memory op may wait in REQ+WAIT_RD before it is aborted with MemErr (range 2..255)

Ports:
Clk  in  1  pipeline clock, rising edge
Reset  in  1  asynchronous, active-low reset
RegWriteIn, MemWriteIn, MemReadIn, BranchIn, MemToRegIn, JumpIn, JrIn, JalIn, ZeroIn  in  1 each  EX/MEM control bits
RData2In  in  32  store data
ALUResultIn  in  32  memory address / ALU result / jr target
PCAddResultIn  in  32  PC+4
BranchPCIn  in  32  branch or jump target
RdRegIn  in  5  destination register
DmReq  out  1  memory request valid
DmWe  out  1  1=write, 0=read
DmAddr  out  32  equals ALUResultIn
DmWData  out  32  equals RData2In
DmReady  in  1  memory accepts the request this cycle
DmRValid  in  1  read data valid
DmRData  in  32  read data
Stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
PCSrc  out  1  redirect PC
PCTarget  out  32  redirect address
Flush  out  1  squash IF/ID and ID/EX
MemErr  out  1  sticky error flag
RegWriteOut, MemToRegOut, JalOut  out  1 each  MEM/WB control bits
ReadDataOut, ALUResultOut, PCAddResultOut  out  32 each  MEM/WB data
RdRegOut  out  5  MEM/WB destination register

Behaviour:
- Reset low: state=IDLE, timeout counter=0, all registered outputs=0, MemErr=0. Reset mid-access abandons the access with no further DmReq.
- Memory op = MemReadIn|MemWriteIn. If both are set, it is treated as a read.
- Misaligned access (ALUResultIn[1:0]!=0) on a memory op: no DmReq is issued, MemErr is set, and the op completes in the same cycle as a bubble.
- FSM states IDLE, REQ, WAIT_RD.
- IDLE, non-memory op: completes in the same cycle.
- IDLE, memory op: DmReq=1 combinationally.
  - Write with DmReady: completes.
  - Read with DmReady: goes to WAIT_RD.
  - No DmReady: goes to REQ.
- REQ: DmReq held with stable DmWe/DmAddr/DmWData until DmReady. Write then completes; read goes to WAIT_RD. DmRValid in the same cycle as DmReady is ignored.
- WAIT_RD: DmReq=0. DmRValid completes the op and captures DmRData.
- Timeout counter: cleared in IDLE, increments each cycle in REQ or WAIT_RD. When it reaches TIMEOUT_CYCLES-1 without completion:
  - abort, set MemErr, return to IDLE;
  - complete as a bubble;
  - DmReady/DmRValid arriving in that cycle are ignored.
- Stall = memory op present and not completing this cycle. It is combinational.
- On the completing edge, MEM/WB captures RegWrite, MemToReg, Jal, ALUResult, PCAddResult, RdReg. ReadDataOut = DmRData for reads, else 0.
- Edge without completion (Stall=1) or bubble: RegWriteOut=MemToRegOut=JalOut=0. The other MEM/WB outputs hold their values.
- Redirect on the completing edge (registered, 1-cycle pulse), priority Jr > Jump/Jal > Branch&Zero:
  - Jr: PCTarget=ALUResultIn.
  - Jump or Jal: PCTarget=BranchPCIn.
  - Taken branch: PCTarget=BranchPCIn.
  - Flush=PCSrc. Otherwise PCSrc=Flush=0 and PCTarget holds.
- Jal: RegWriteOut=1 and RdRegOut=31 regardless of RdRegIn.
- MemErr clears only on reset.
- Inputs are sampled only in IDLE, or when completing. EX/MEM is frozen by Stall, so inputs stay stable.

Test Plan:
1. Reset low with DmReady=1 and a memory op on the inputs -> all outputs 0, DmReq=0. Release reset -> DmReq=1 in the first IDLE cycle.
2. LW from 0x100 (RdRegIn=8); DmReady immediate, DmRValid 3 cycles later with 0xDEADBEEF -> Stall high 3 cycles; next edge RegWriteOut=1, MemToRegOut=1, ReadDataOut=0xDEADBEEF, RdRegOut=8.
3. SW to 0x204 with data 0x1234, DmReady withheld 2 cycles -> DmReq/DmAddr/DmWData stable 3 cycles; RegWriteOut=0; Stall low once DmReady=1.
4. BEQ with ZeroIn=1, BranchPCIn=0x40 -> one-cycle PCSrc=1, Flush=1, PCTarget=0x40. Repeat with ZeroIn=0 -> PCSrc=0.
5. JAL to 0x400 with PCAddResultIn=0x1C -> PCTarget=0x400, RegWriteOut=1, RdRegOut=31, PCAddResultOut=0x1C. Jr and Jump both set with ALUResultIn=0x80 -> PCTarget=0x80.
6. LW at 0x102 -> no DmReq, MemErr=1, bubble. LW with DmRValid never asserted -> abort after 16 cycles, MemErr=1, Stall drops, RegWriteOut=0.
